// File: rtl/line_buf_pkg.sv
// Shared types and width helpers for the line-buffer window controller and its
// raster counter.
package line_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Rows of padding above and below the window centre.
  function automatic int half_of(input int num_lines);
    return num_lines / 2;
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Raster column/row counter with a run-time row limit, so the same counter walks
// the image rows and then the padding rows during flush.
module frame_counter
  import line_buf_pkg::*;
#(
  parameter int COL_MAX = 1024,
  parameter int ROW_MAX = 480,
  localparam int CW = cnt_w(COL_MAX),
  localparam int RW = cnt_w(ROW_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic [RW-1:0] i_row_last,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_eol,
  output logic          o_last
);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  assign o_eol  = (r_col == CW'(COL_MAX - 1));
  assign o_last = o_eol && (r_row == i_row_last);
  assign o_col  = r_col;
  assign o_row  = r_row;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (o_eol) begin
        r_col <= '0;
        r_row <= o_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_window_controller.sv
// Sequences a chain of line buffers feeding a (NUM_LINES+1)-row window: raster
// tracking, buffer enables, real-data tap mask and optional end-of-frame flush.
module line_window_controller
  import line_buf_pkg::*;
#(
  parameter int IMG_WIDTH  = 1024,
  parameter int IMG_HEIGHT = 480,
  parameter int NUM_LINES  = 2,
  parameter int PAD        = 1,
  localparam int CW = cnt_w(IMG_WIDTH),
  localparam int RW = cnt_w(IMG_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [NUM_LINES-1:0] wr_en_o,
  output logic [NUM_LINES-1:0] rd_en_o,
  output logic                 win_valid_o,
  output logic [NUM_LINES:0]   win_rows_o,
  output logic                 flush_o,
  output logic [CW-1:0]        col_o,
  output logic [RW-1:0]        row_o,
  output logic                 done_o
);

  localparam int HALF    = half_of(NUM_LINES);
  localparam int WIN_ROW = (PAD != 0) ? HALF : NUM_LINES;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_run;
  logic          w_flush;
  logic          w_acc;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [31:0]   w_row_x;
  logic [RW-1:0] w_row_last;
  logic          w_eol;
  logic          w_last;

  assign w_run   = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign w_flush = (r_state == ST_FLUSH);
  assign ready_o = !rst && w_run;
  assign w_acc   = valid_i && ready_o;
  assign w_row_x = 32'(w_row);

  // During flush the row counter indexes padding rows, so its limit drops to HALF.
  assign w_row_last = w_flush ? RW'(HALF - 1) : RW'(IMG_HEIGHT - 1);

  frame_counter #(
    .COL_MAX (IMG_WIDTH),
    .ROW_MAX (IMG_HEIGHT)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_acc || w_flush),
    .i_clr      (r_state == ST_DONE),
    .i_row_last (w_row_last),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_eol      (w_eol),
    .o_last     (w_last)
  );

  // NOTE: every signal driven here gets a default first, so no path through the
  // case leaves a value held and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (w_acc) begin
          if (w_eol && w_last) w_state_nxt = (PAD != 0) ? ST_FLUSH : ST_DONE;
          else                 w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    wr_en_o     = '0;
    rd_en_o     = '0;
    win_valid_o = 1'b0;
    win_rows_o  = '0;
    flush_o     = 1'b0;
    done_o      = 1'b0;
    if (!rst) begin
      if (w_run) begin
        win_rows_o[0] = 1'b1;
        for (int i = 1; i <= NUM_LINES; i++) win_rows_o[i] = (w_row_x >= i);
        for (int i = 0; i < NUM_LINES; i++) begin
          wr_en_o[i] = w_acc && (w_row_x >= i);
          rd_en_o[i] = w_acc && (w_row_x >= i + 1);
        end
        win_valid_o = w_acc && (w_row_x >= WIN_ROW);
      end else if (w_flush) begin
        // Bottom padding: tap i still holds real data only above flush row f.
        flush_o     = 1'b1;
        wr_en_o     = '1;
        rd_en_o     = '1;
        win_valid_o = 1'b1;
        for (int i = 0; i <= NUM_LINES; i++) win_rows_o[i] = (i >= w_row_x + 1);
      end else begin
        done_o = 1'b1;
      end
    end
  end

  assign col_o = rst ? '0 : w_col;
  assign row_o = rst ? '0 : w_row;

endmodule
